// File: rtl/universal_threshold_estimator_pkg.sv
// Shared types and helpers for the universal threshold estimator and the
// downstream thresholding path.
package universal_threshold_estimator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_MEAN,
        ST_SCALE,
        ST_OUTPUT
    } state_e;

    localparam int unsigned SCALE_FRAC_DEF = 12;
    localparam int unsigned SCALE_ONE      = 1 << SCALE_FRAC_DEF;

    // Magnitude of a w-bit signed value; the most negative code folds onto
    // the most positive one so the result always fits in w-1 bits.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] x,
                                            input int unsigned         w);
        logic signed [31:0] lo;
        lo = -(32'sd1 <<< (w - 1));
        if (x <= lo)
            return (32'd1 << (w - 1)) - 32'd1;
        return (x < 0) ? 32'(-x) : 32'(x);
    endfunction

    function automatic logic [63:0] sat_pos(input logic [63:0] v,
                                            input int unsigned w);
        logic [63:0] m;
        m = (64'd1 << (w - 1)) - 64'd1;
        return (v > m) ? m : v;
    endfunction

endpackage

// File: rtl/universal_threshold_estimator_abs_accumulator.sv
// Sums saturated magnitudes of accepted coefficients and flags the cycle in
// which the final sample of the window is accepted.
module universal_threshold_estimator_abs_accumulator
    import universal_threshold_estimator_pkg::*;
#(
    parameter int ADC_WIDTH      = 14,
    parameter int MAX_WINDOW_LOG = 10,
    parameter int ACC_W          = ADC_WIDTH - 1 + MAX_WINDOW_LOG,
    parameter int WL_W           = $clog2(MAX_WINDOW_LOG + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_i,
    input  logic                        enable_i,
    input  logic                        valid_i,
    input  logic signed [ADC_WIDTH-1:0] level_i,
    input  logic        [WL_W-1:0]      window_log_i,
    output logic        [ACC_W-1:0]     acc_o,
    output logic                        done_o
);

    localparam int CNT_W = MAX_WINDOW_LOG + 1;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ADC_WIDTH-2:0] abs_val;
    logic                 accept;

    always_comb begin
        abs_val = (ADC_WIDTH - 1)'(sat_abs(32'(level_i), ADC_WIDTH));
        accept  = enable_i & valid_i;
        done_o  = accept && (cnt_q == ((CNT_W'(1) << window_log_i) - CNT_W'(1)));
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            acc_d = acc_q + ACC_W'(abs_val);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/universal_threshold_estimator.sv
// Window mean-absolute-value scaled by a runtime Q-format factor, producing a
// saturated +/- threshold pair held until the next window completes.
module universal_threshold_estimator
    import universal_threshold_estimator_pkg::*;
#(
    parameter int  ADC_WIDTH       = 14,
    parameter int  MAX_WINDOW_SIZE = 1024,
    parameter int  SCALE_WIDTH     = 16,
    parameter int  SCALE_FRAC      = SCALE_FRAC_DEF,
    localparam int MAX_WINDOW_LOG  = $clog2(MAX_WINDOW_SIZE),
    localparam int WL_W            = $clog2(MAX_WINDOW_LOG + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic        [WL_W-1:0]        window_log,
    input  logic        [SCALE_WIDTH-1:0] scale_factor,
    input  logic                          detail_valid,
    input  logic signed [ADC_WIDTH-1:0]   detail_level,
    output logic                          busy,
    output logic                          threshold_valid,
    output logic signed [ADC_WIDTH-1:0]   universal_threshold_positive,
    output logic signed [ADC_WIDTH-1:0]   universal_threshold_negative
);

    localparam int ACC_W = ADC_WIDTH - 1 + MAX_WINDOW_LOG;

    state_e                     state_q, state_d;
    logic [WL_W-1:0]            wl_q;
    logic [SCALE_WIDTH-1:0]     scale_q;
    logic [ACC_W-1:0]           mean_q;
    logic signed [ADC_WIDTH-1:0] pos_q, neg_q;

    logic [ACC_W-1:0]     acc;
    logic                 acc_done;
    logic                 accept_start;
    logic [WL_W-1:0]      wl_clamped;
    logic [63:0]          prod_full;
    logic [ADC_WIDTH-1:0] prod_sat;

    assign accept_start = (state_q == ST_IDLE) && start;
    assign wl_clamped   = (32'(window_log) > 32'(MAX_WINDOW_LOG)) ? WL_W'(MAX_WINDOW_LOG)
                                                                  : window_log;

    universal_threshold_estimator_abs_accumulator #(
        .ADC_WIDTH      (ADC_WIDTH),
        .MAX_WINDOW_LOG (MAX_WINDOW_LOG)
    ) u_abs_acc (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (accept_start),
        .enable_i     (state_q == ST_ACCUM),
        .valid_i      (detail_valid),
        .level_i      (detail_level),
        .window_log_i (wl_q),
        .acc_o        (acc),
        .done_o       (acc_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACCUM;
            ST_ACCUM:  if (acc_done) state_d = ST_MEAN;
            ST_MEAN:   state_d = ST_SCALE;
            ST_SCALE:  state_d = ST_OUTPUT;
            ST_OUTPUT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prod_full = (64'(mean_q) * 64'(scale_q)) >> SCALE_FRAC;
        prod_sat  = ADC_WIDTH'(sat_pos(prod_full, ADC_WIDTH));
    end

    // Thresholds load at the end of SCALE so they are already visible during
    // the OUTPUT cycle that carries threshold_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wl_q    <= '0;
            scale_q <= '0;
            mean_q  <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                wl_q    <= wl_clamped;
                scale_q <= scale_factor;
            end
            if (state_q == ST_MEAN)
                mean_q <= acc >> wl_q;
            if (state_q == ST_SCALE) begin
                pos_q <= prod_sat;
                neg_q <= -prod_sat;
            end
        end
    end

    assign busy                         = (state_q != ST_IDLE);
    assign threshold_valid              = (state_q == ST_OUTPUT);
    assign universal_threshold_positive = pos_q;
    assign universal_threshold_negative = neg_q;

endmodule

// File: tb/tb_universal_threshold_estimator.sv
// Directed and randomized windows checked against a plain-arithmetic model of
// the mean-absolute-value threshold.
module tb_universal_threshold_estimator;
    import universal_threshold_estimator_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic        [3:0]  window_log;
    logic        [15:0] scale_factor;
    logic               detail_valid;
    logic signed [13:0] detail_level;
    logic               busy;
    logic               threshold_valid;
    logic signed [13:0] thr_pos;
    logic signed [13:0] thr_neg;

    int checks   = 0;
    int errors   = 0;
    int prev_pos = 0;

    universal_threshold_estimator dut (
        .clk                          (clk),
        .rst                          (rst),
        .start                        (start),
        .window_log                   (window_log),
        .scale_factor                 (scale_factor),
        .detail_valid                 (detail_valid),
        .detail_level                 (detail_level),
        .busy                         (busy),
        .threshold_valid              (threshold_valid),
        .universal_threshold_positive (thr_pos),
        .universal_threshold_negative (thr_neg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Mean of saturated magnitudes over 2^w samples, scaled and clipped.
    function automatic int model(input int wl, input int scale, input int s[$]);
        longint sum = 0;
        longint mean;
        longint p;
        int     w = (wl > 10) ? 10 : wl;
        foreach (s[i]) sum += (s[i] == -8192) ? 8191 : ((s[i] < 0) ? -s[i] : s[i]);
        mean = sum / (longint'(1) << w);
        p    = (mean * scale) / SCALE_ONE;
        if (p > 8191) p = 8191;
        return int'(p);
    endfunction

    task automatic run_window(input string name, input int wl, input int scale,
                              input int s[$], input int gap, input int restart_idx);
        int exp_v;
        int early;
        int lat;
        exp_v        = model(wl, scale, s);
        window_log   = 4'(wl);
        scale_factor = 16'(scale);
        start        = 1'b1;
        detail_valid = 1'b1;
        detail_level = 14'($urandom);
        tick();
        start        = 1'b0;
        detail_valid = 1'b0;
        check({name, "_busy_after_start"}, 32'(busy), 1);
        early = 0;
        foreach (s[i]) begin
            if (i == restart_idx) begin
                start        = 1'b1;
                window_log   = 4'd0;
                scale_factor = 16'hFFFF;
            end
            detail_valid = 1'b1;
            detail_level = 14'(s[i]);
            tick();
            start        = 1'b0;
            detail_valid = 1'b0;
            if (threshold_valid) early++;
            if (i != s.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    detail_level = 14'($urandom);
                    tick();
                    if (threshold_valid) early++;
                end
            end
        end
        check({name, "_no_early_valid"}, early, 0);
        check({name, "_held_pos"}, 32'(thr_pos), prev_pos);
        lat = 1;
        while (!threshold_valid && lat < 12) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_pos"}, 32'(thr_pos), exp_v);
        check({name, "_neg"}, 32'(thr_neg), -exp_v);
        prev_pos = exp_v;
        tick();
        check({name, "_busy_drop"}, 32'(busy), 0);
        check({name, "_valid_pulse"}, 32'(threshold_valid), 0);
        check({name, "_pos_hold"}, 32'(thr_pos), exp_v);
    endtask

    initial begin
        int s[$];
        int tv_seen;

        rst          = 1'b1;
        start        = 1'b0;
        window_log   = '0;
        scale_factor = '0;
        detail_valid = 1'b0;
        detail_level = '0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(threshold_valid), 0);
        check("reset_pos", 32'(thr_pos), 0);
        check("reset_neg", 32'(thr_neg), 0);
        rst = 1'b0;
        tick();

        s = '{10, -20, 30, -40};
        run_window("basic", 2, SCALE_ONE, s, 0, -1);
        run_window("gapped", 2, 8192, s, 2, -1);
        s = '{-8192, -8192};
        run_window("saturate", 1, 16384, s, 1, -1);
        s = '{1, 2, 2, 2};
        run_window("truncate", 2, 6144, s, 0, -1);
        s = '{50, -60, 70, -80};
        run_window("restart_ignored", 2, SCALE_ONE, s, 1, 2);
        s = '{5};
        run_window("single", 0, 12288, s, 0, -1);

        s = {};
        for (int i = 0; i < 1024; i++) s.push_back(int'($urandom_range(0, 16383)) - 8192);
        run_window("clamp", 15, 20000, s, 0, -1);

        // Reset three samples into a window: nothing may be published.
        window_log   = 4'd2;
        scale_factor = 16'(SCALE_ONE);
        start        = 1'b1;
        tick();
        start        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            detail_valid = 1'b1;
            detail_level = 14'sd500;
            tick();
        end
        detail_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_busy", 32'(busy), 0);
        check("midreset_valid", 32'(threshold_valid), 0);
        check("midreset_pos", 32'(thr_pos), 0);
        check("midreset_neg", 32'(thr_neg), 0);
        tv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            detail_valid = 1'b1;
            detail_level = 14'($urandom);
            tick();
            if (threshold_valid || busy) tv_seen++;
        end
        detail_valid = 1'b0;
        check("idle_ignores_samples", tv_seen, 0);
        prev_pos = 0;
        s = '{100, 100, 100, 100};
        run_window("after_reset", 2, SCALE_ONE, s, 0, -1);

        for (int t = 0; t < 6; t++) begin
            int wl;
            int n;
            s  = {};
            wl = int'($urandom_range(0, 4));
            n  = 1 << wl;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) s.push_back(-8192);
                else s.push_back(int'($urandom_range(0, 16383)) - 8192);
            end
            run_window("random", wl, int'($urandom_range(0, 65535)), s,
                       int'($urandom_range(0, 2)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/universal_threshold_estimator.md
Name: universal_threshold_estimator

Overview:
- Upstream neighbour of the detail-coefficient thresholding stage; produces the signed positive/negative universal threshold pair it consumes.
- Collects one window of detail coefficients, forms mean absolute value, scales by a runtime Q-format factor (sigma*sqrt(2 ln N) folded in by software), saturates, and holds the result until the next window completes.

Parameters:
- ADC_WIDTH, 14, coefficient and threshold width (signed two's complement)
- MAX_WINDOW_SIZE, 1024, largest window in samples (power of two)
- MAX_WINDOW_LOG, $clog2(MAX_WINDOW_SIZE), localparam, log2 of max window
- SCALE_WIDTH, 16, width of unsigned scale factor
- SCALE_FRAC, 12, fractional bits of scale factor (4096 = 1.0)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a new window when idle
- window_log  in  $clog2(MAX_WINDOW_LOG+1)  window = 2^window_log samples; sampled on accepted start
- scale_factor  in  SCALE_WIDTH  unsigned Q(SCALE_WIDTH-SCALE_FRAC).SCALE_FRAC; sampled on accepted start
- detail_valid  in  1  detail_level valid this cycle
- detail_level  in  ADC_WIDTH  signed detail coefficient
- busy  out  1  high from accepted start until threshold_valid cycle inclusive
- threshold_valid  out  1  one-cycle pulse when new thresholds are presented
- universal_threshold_positive  out  ADC_WIDTH  signed, >= 0
- universal_threshold_negative  out  ADC_WIDTH  signed, exact negation of positive

Behaviour:
- Reset: state IDLE; busy=0, threshold_valid=0, both thresholds=0; accumulator/counter cleared. Reset mid-window aborts without output update.
- FSM IDLE -> ACCUM (start=1) -> MEAN -> SCALE -> OUTPUT -> IDLE.
- IDLE: start latches window_log (values > MAX_WINDOW_LOG clamp to MAX_WINDOW_LOG), scale_factor; clears accumulator and counter. detail_valid ignored in IDLE.
- ACCUM: each cycle with detail_valid=1 adds |detail_level| and increments counter; gaps in detail_valid allowed. Sample on the start cycle is NOT accumulated. Exit after 2^window_log accepted samples (window_log=0 -> 1 sample).
- start while busy: ignored, no effect on window in progress.
- |x|: -2^(ADC_WIDTH-1) maps to 2^(ADC_WIDTH-1)-1 (saturated).
- Accumulator width ADC_WIDTH-1+MAX_WINDOW_LOG unsigned; never overflows.
- MEAN: mean = accumulator >> window_log (truncating), registered.
- SCALE: product = (mean * scale_factor) >> SCALE_FRAC (truncating), saturated to 2^(ADC_WIDTH-1)-1, registered.
- OUTPUT: positive=product, negative=-product updated; threshold_valid=1 this cycle only; busy drops next cycle.
- Latency: last sample accepted cycle N -> threshold_valid high cycle N+3, outputs visible from N+3 and held until next OUTPUT or reset.
- detail_valid during MEAN/SCALE/OUTPUT ignored (upstream must not stream across windows without restart).

Decomposition:
- Shared package: FSM state enum, SCALE_ONE constant (1<<SCALE_FRAC), saturating-abs and saturate-to-signed-max functions reused by thresholding path.
- One natural sub-module: abs_accumulator (saturating abs + counter + accumulate, done flag); FSM/scale/output in top.

Test Plan:
- window_log=2, scale=4096, samples 10,-20,30,-40 -> threshold_valid 3 cycles after 4th sample; positive=25, negative=-25; busy low next cycle.
- window_log=2, scale=8192, same samples with 2-cycle gaps between valids -> 50/-50; latency measured from last valid still 3.
- window_log=1, scale=16384, samples -8192,-8192 -> abs 8191 each, mean 8191, product 32764 saturates -> 8191/-8191.
- window_log=2, scale=6144, samples 1,2,2,2 -> mean 1 (7>>2), product 1 (6144>>12 truncated) -> 1/-1; prior outputs held until this pulse.
- start pulsed again after 2 samples of a 4-sample window -> ignored; result from original 4 samples only; window_log=15 at start clamps to 10 (1024 samples required).
- rst asserted after 3 of 4 samples -> all outputs 0, busy 0, no threshold_valid; new start with 4 samples of 100 -> 100/-100.
